demosaic_frame_ctrl: RTL and testbench
======================================

# demosaic_frame_ctrl

Frame sequencer for the neighbour demosaic stage. It clears the demosaic before each frame and forwards exactly width*height Bayer pixels from the upstream stream, honouring downstream backpressure. It then injects the zero-pixel flush beats the demosaic needs to emit its last rows, waits for the demosaic's done, and reports completion with a pixel-count check. It sits between the sensor/frame-buffer FIFO and the demosaic, and owns that stage's iValid, iData and reset.

## Interface
- width, 1920: pixels per row
- height, 1080: rows per frame
- kernelSize, 7: demosaic kernel; boundaryWidth = (kernelSize-1)/2
- drainTimeout, 15: max cycles in DRAIN before error

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iStart  in  1  pulse; begin one frame (ignored unless IDLE)
- iData  in  8  upstream Bayer pixel
- iValid  in  1  upstream pixel available
- oReady  out  1  combinational; upstream beat taken when iValid & oReady
- iSinkReady  in  1  downstream (RGB consumer) can accept
- oDmData  out  8  registered; to demosaic iData
- oDmValid  out  1  registered; to demosaic iValid
- oDmReset  out  1  to demosaic reset
- iDmValid  in  1  demosaic oValid
- iDmDone  in  1  demosaic oDone
- oBusy  out  1  high in any state except IDLE
- oDone  out  1  one-cycle pulse at frame end
- oError  out  1  sticky until next accepted iStart
- oPixCnt  out  32  demosaic output pixels counted this frame

## Operation
- Constants: FRAME = width*height; FLUSH = width*(boundaryWidth+1); total beats per frame = FRAME+FLUSH.
- States: IDLE, CLR, FILL, FLUSH, DRAIN, DONE.
- IDLE: no beats. iStart -> CLR; clears oError, oPixCnt, inCnt, flushCnt, drainCnt.
- CLR: one cycle; oDmReset = 1 -> FILL.
- FILL: oReady = iSinkReady. beat = iValid & iSinkReady; on beat, oDmData <= iData, inCnt++. Beat with inCnt == FRAME-1 -> FLUSH.
- FLUSH: beat = iSinkReady, oDmData <= 0, flushCnt++. Beat with flushCnt == FLUSH-1 -> DRAIN.
- oDmValid <= beat every cycle. It is 0 in IDLE, CLR, DRAIN and DONE. oReady = 0 outside FILL.
- oPixCnt increments on every cycle with iDmValid = 1 while oBusy (saturates at 2^32-1).
- DRAIN: iDmDone = 1 -> DONE. drainCnt reaching drainTimeout -> oError = 1, -> DONE.
- DONE: oDone = 1 for one cycle. oError |= (oPixCnt != FRAME), where the count includes any iDmValid sampled in this cycle. -> IDLE.
- iStart outside IDLE is ignored. oDmReset = reset | (state == CLR).
- Sink contract: the sink absorbs one beat arriving up to 2 cycles after it drops iSinkReady (demosaic output lags the beat).

## Timing
- Reset values: state IDLE; oDmValid 0, oDmData 0, oDone 0, oError 0, oBusy 0, oPixCnt 0, oReady 0; oDmReset 1 while reset is high.
- iStart at cycle t: CLR at t+1 (oDmReset high), FILL at t+2; the earliest oReady is at t+2.
- Upstream beat at cycle c: oDmValid/oDmData at c+1; demosaic output at c+2.
- Last flush beat at c: oDmValid high at c+1, iDmDone at c+2, state DONE at c+3, oDone pulse at c+3, state IDLE at c+4.
- Stall (iSinkReady = 0 or iValid = 0 in FILL): no beat is issued and counters hold. The demosaic holds state because its iValid is low.
- Reset mid-frame: immediately IDLE. The demosaic is reset through oDmReset. A partial frame is discarded with no oDone.

## Test plan
- Small frame: width=4, height=4, kernelSize=7, upstream always valid, sink always ready -> 16 data beats, then 16 zero beats on consecutive cycles. With a behavioural demosaic model, oPixCnt = 16, oDone pulses once, oError = 0.
- Backpressure: same frame, iSinkReady toggles every 3 cycles, iValid random 50% -> still exactly 32 oDmValid beats, oDmData order matches the input, and no beat occurs while iSinkReady = 0.
- Missing done: model never asserts iDmDone -> DRAIN for 15 cycles, then oDone pulse with oError = 1.
- Short output: model emits 15 iDmValid -> oDone with oError = 1, oPixCnt = 15. The next iStart clears oError.
- iStart pulsed during FILL -> ignored; beat count stays 32, single oDone.
- Reset asserted after 10 beats -> oBusy 0, oDmReset 1 during reset. A new iStart then runs a full clean frame with 32 beats and oError = 0.

Source files
------------

// File: rtl/demosaic_frame_ctrl_if.sv
// Stream bundle between the upstream pixel FIFO, the frame controller and the demosaic stage.
// Names are from the controller's point of view: i* flows into it, o* flows out of it.
interface demosaic_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] iData;
  logic              iValid;
  logic              oReady;
  logic              iSinkReady;
  logic [DATA_W-1:0] oDmData;
  logic              oDmValid;
  logic              oDmReset;
  logic              iDmValid;
  logic              iDmDone;

  modport slave (
    input  iData, iValid, iSinkReady, iDmValid, iDmDone,
    output oReady, oDmData, oDmValid, oDmReset
  );

  modport master (
    output iData, iValid, iSinkReady, iDmValid, iDmDone,
    input  oReady, oDmData, oDmValid, oDmReset
  );
endinterface

// File: rtl/demosaic_frame_ctrl.sv
// Frame sequencer for the neighbour demosaic: clear, forward one frame of Bayer pixels,
// inject zero flush beats, wait for the demosaic's done and check the output pixel count.
module demosaic_frame_ctrl #(
  parameter int DATA_W        = 8,
  parameter int WIDTH         = 1920,
  parameter int HEIGHT        = 1080,
  parameter int KERNEL_SIZE   = 7,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iStart,
  demosaic_frame_ctrl_if.slave bus,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oError,
  output logic [31:0]          oPixCnt
);

  localparam logic [31:0] FRAME_N    = 32'(WIDTH * HEIGHT);
  localparam logic [31:0] FLUSH_N    = 32'(WIDTH * ((KERNEL_SIZE - 1) / 2 + 1));
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [31:0]       in_cnt_q, in_cnt_d;
  logic [31:0]       flush_cnt_q, flush_cnt_d;
  logic [31:0]       drain_cnt_q, drain_cnt_d;
  logic [31:0]       pix_cnt_q, pix_cnt_d;
  logic              error_q, error_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] dm_data_q, dm_data_d;
  logic              beat;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    error_d     = error_q;
    dm_data_d   = dm_data_q;
    beat        = 1'b0;

    // Output pixels are counted in every busy state, saturating at all-ones.
    pix_cnt_d = pix_cnt_q;
    if ((state_q != S_IDLE) && bus.iDmValid && (pix_cnt_q != 32'hFFFF_FFFF))
      pix_cnt_d = pix_cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d     = S_CLR;
          error_d     = 1'b0;
          pix_cnt_d   = '0;
          in_cnt_d    = '0;
          flush_cnt_d = '0;
          drain_cnt_d = '0;
        end
      end
      S_CLR: state_d = S_FILL;
      S_FILL: begin
        if (bus.iValid && bus.iSinkReady) begin
          beat      = 1'b1;
          dm_data_d = bus.iData;
          in_cnt_d  = in_cnt_q + 32'd1;
          if (in_cnt_q == FRAME_N - 32'd1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bus.iSinkReady) begin
          beat        = 1'b1;
          dm_data_d   = '0;
          flush_cnt_d = flush_cnt_q + 32'd1;
          if (flush_cnt_q == FLUSH_N - 32'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.iDmDone) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        // pix_cnt_d already includes an output sampled in this very cycle.
        error_d = error_q | (pix_cnt_d != FRAME_N);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    dm_valid_d = beat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      pix_cnt_q   <= '0;
      error_q     <= 1'b0;
      dm_valid_q  <= 1'b0;
      dm_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      error_q     <= error_d;
      dm_valid_q  <= dm_valid_d;
      dm_data_q   <= dm_data_d;
    end
  end

  assign bus.oReady   = (state_q == S_FILL) && bus.iSinkReady;
  assign bus.oDmData  = dm_data_q;
  assign bus.oDmValid = dm_valid_q;
  assign bus.oDmReset = reset || (state_q == S_CLR);
  assign oBusy        = (state_q != S_IDLE);
  assign oDone        = (state_q == S_DONE);
  assign oError       = error_q;
  assign oPixCnt      = pix_cnt_q;

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// Bench for demosaic_frame_ctrl on a 4x4 frame with a behavioural demosaic model;
// a driver queues expected beats and frame results, a monitor pops and compares them.
module tb_demosaic_frame_ctrl;
  localparam int W       = 4;
  localparam int H       = 4;
  localparam int K       = 7;
  localparam int DT      = 15;
  localparam int FRAME_N = W * H;
  localparam int FLUSH_N = W * ((K - 1) / 2 + 1);
  localparam int TOTAL_N = FRAME_N + FLUSH_N;

  typedef struct {
    bit err;
    int pix;
    int lat;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iStart = 1'b0;
  logic        oBusy, oDone, oError;
  logic [31:0] oPixCnt;

  demosaic_frame_ctrl_if #(.DATA_W(8)) bus ();

  demosaic_frame_ctrl #(
    .DATA_W(8), .WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(K), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .bus(bus.slave),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oPixCnt(oPixCnt)
  );

  always #5 clk = ~clk;

  logic [7:0] pix_tab [16];
  logic [7:0] exp_q [$];
  done_t      done_q [$];
  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;
  int cyc_n = 0;
  int last_beat_cyc = 0;
  bit prev_sink = 1'b0;

  // Behavioural demosaic: the first FLUSH_N input beats only fill its line buffers,
  // every later beat yields one output pixel; done accompanies the last output.
  int m_cnt = 0;
  int m_out = 0;
  int m_limit = FRAME_N;
  bit m_done_en = 1'b1;

  always @(posedge clk) begin
    if (bus.oDmReset) begin
      m_cnt <= 0;
      m_out <= 0;
      bus.iDmValid <= 1'b0;
      bus.iDmDone  <= 1'b0;
    end else begin
      bus.iDmValid <= 1'b0;
      bus.iDmDone  <= 1'b0;
      if (bus.oDmValid) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt >= FLUSH_N && m_out < m_limit) begin
          bus.iDmValid <= 1'b1;
          m_out <= m_out + 1;
        end
        if (m_cnt == TOTAL_N - 1 && m_done_en) bus.iDmDone <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    done_t e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (reset) begin
        prev_sink = 1'b0;
      end else begin
        if (bus.oDmValid) begin
          check("beat_while_sink_ready", prev_sink, 1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_extra: got beat with data %0d, expected no beat", bus.oDmData);
          end else begin
            check("beat_data", bus.oDmData, exp_q.pop_front());
          end
          last_beat_cyc = cyc_n;
        end
        prev_sink = bus.iSinkReady;
        if (oDone) begin
          if (done_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_extra: got oDone=1, expected 0");
          end else begin
            e = done_q.pop_front();
            check("done_beats_left", exp_q.size(), 0);
            check("done_latency", cyc_n - last_beat_cyc, e.lat);
            @(posedge clk);
            #1;
            check("done_pulse_width", oDone, 0);
            check("frame_error", oError, e.err);
            check("frame_pix_cnt", oPixCnt, e.pix);
            check("idle_after_done", oBusy, 0);
            frames_done++;
          end
        end
      end
    end
  end

  task automatic do_reset_abort();
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    bus.iValid = 1'b0;
    iStart = 1'b0;
    @(negedge clk);
    check("abort_dm_reset_comb", bus.oDmReset, 1);
    @(posedge clk);
    #1;
    check("abort_busy", oBusy, 0);
    check("abort_dm_valid", bus.oDmValid, 0);
    check("abort_ready", bus.oReady, 0);
    check("abort_dm_reset", bus.oDmReset, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("after_abort_dm_reset", bus.oDmReset, 0);
  endtask

  task automatic run_frame(input logic [7:0] salt, input bit rnd_valid, input bit tog_sink,
                           input int start_at, input int abort_at,
                           input bit e_err, input int e_pix, input int e_lat);
    done_t e;
    int idx, cyc, f0;
    bit taken, pulsed;
    idx = 0;
    cyc = 0;
    pulsed = 1'b0;
    f0 = frames_done;
    for (int i = 0; i < FRAME_N; i++) exp_q.push_back(pix_tab[i] ^ salt);
    for (int i = 0; i < FLUSH_N; i++) exp_q.push_back(8'h00);
    e.err = e_err;
    e.pix = e_pix;
    e.lat = e_lat;
    done_q.push_back(e);

    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    check("clr_dm_reset", bus.oDmReset, 1);
    check("clr_busy", oBusy, 1);
    check("clr_error_cleared", oError, 0);
    check("clr_pix_cnt", oPixCnt, 0);
    check("clr_ready", bus.oReady, 0);

    while (cyc < 400 && (idx < FRAME_N || frames_done == f0)) begin
      bus.iData  = (idx < FRAME_N) ? (pix_tab[idx] ^ salt) : 8'h00;
      bus.iValid = (idx < FRAME_N) && (!rnd_valid || $urandom_range(0, 1) == 1);
      bus.iSinkReady = !tog_sink || ((cyc / 3) % 2 == 0);
      iStart = 1'b0;
      if (start_at >= 0 && idx == start_at && !pulsed) begin
        iStart = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      taken = bus.iValid && bus.oReady;
      @(posedge clk);
      #1;
      cyc++;
      if (taken) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        do_reset_abort();
        bus.iSinkReady = 1'b1;
        return;
      end
    end
    iStart = 1'b0;
    bus.iValid = 1'b0;
    bus.iSinkReady = 1'b1;
    if (frames_done == f0) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: got no oDone after %0d cycles, expected one", cyc);
    end
  endtask

  initial begin
    pix_tab = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    bus.iData = 8'h00;
    bus.iValid = 1'b0;
    bus.iSinkReady = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dm_valid", bus.oDmValid, 0);
    check("rst_dm_data", bus.oDmData, 0);
    check("rst_done", oDone, 0);
    check("rst_error", oError, 0);
    check("rst_busy", oBusy, 0);
    check("rst_pix_cnt", oPixCnt, 0);
    check("rst_ready", bus.oReady, 0);
    check("rst_dm_reset", bus.oDmReset, 1);
    reset = 1'b0;
    bus.iSinkReady = 1'b1;
    @(posedge clk);
    #1;
    check("idle_dm_reset", bus.oDmReset, 0);
    check("idle_busy", oBusy, 0);

    // Clean frame, upstream always valid, sink always ready.
    run_frame(8'h00, 1'b0, 1'b0, -1, -1, 1'b0, FRAME_N, 2);
    // Backpressure and random upstream gaps.
    run_frame(8'h5A, 1'b1, 1'b1, -1, -1, 1'b0, FRAME_N, 2);
    // Demosaic never raises done: drain timeout.
    m_done_en = 1'b0;
    run_frame(8'hA5, 1'b0, 1'b0, -1, -1, 1'b1, FRAME_N, DT);
    m_done_en = 1'b1;
    // Demosaic produces one pixel short.
    m_limit = FRAME_N - 1;
    run_frame(8'h3C, 1'b0, 1'b0, -1, -1, 1'b1, FRAME_N - 1, 2);
    m_limit = FRAME_N;
    repeat (3) @(posedge clk);
    #1;
    check("error_sticky", oError, 1);
    // Next frame clears the error; iStart during FILL is ignored.
    run_frame(8'hC3, 1'b0, 1'b0, 5, -1, 1'b0, FRAME_N, 2);
    // Reset after 10 beats, then a full clean frame.
    run_frame(8'h0F, 1'b0, 1'b0, -1, 10, 1'b0, FRAME_N, 2);
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_abort", frames_done, 5);
    run_frame(8'hF0, 1'b1, 1'b0, -1, -1, 1'b0, FRAME_N, 2);
    repeat (5) @(posedge clk);
    #1;
    check("total_frames", frames_done, 6);
    check("beats_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
